ace_snoop_responder: RTL and testbench

- Cache-side responder for the ACE snoop channels (AC request, CR response, CD data).
- Accepts one snoop at a time and looks up the line through a single-port tag/data access interface.
- Updates the coherence state when required, returns CR, then streams the line on CD when data transfer is required.
- Sits between the snoop bus and the std_cache controller; it is the counterpart of the bench snoop initiator.

---
 rtl/snoop_resp_pkg.sv | 30 +++
 rtl/ace_snoop_responder_if.sv | 47 ++++
 rtl/snoop_resp_decode.sv | 62 ++++++
 rtl/ace_snoop_responder.sv | 167 ++++++++++++++++
 tb/tb_ace_snoop_responder.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snoop_resp_pkg.sv
`timescale 1ns/1ps
// Shared types for the ACE snoop responder: snoop codes, CR bit positions, FSM states, decode result.
package snoop_resp_pkg;

  localparam logic [3:0] SNP_READ_ONCE     = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED   = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN    = 4'b0010;
  localparam logic [3:0] SNP_READ_NSD      = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE   = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED  = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID  = 4'b1101;

  // cr_resp = {WasUnique, IsShared, PassDirty, Error, DataTransfer}
  localparam int CR_DT  = 0;
  localparam int CR_ERR = 1;
  localparam int CR_PD  = 2;
  localparam int CR_IS  = 3;
  localparam int CR_WU  = 4;

  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT, UPDATE, RESP, DATA} snp_state_e;

  typedef struct packed {
    logic [4:0] cr_resp;
    logic       need_data;
    logic       inval;
    logic       clean;
  } snp_dec_t;

endpackage

// File: rtl/ace_snoop_responder_if.sv
`timescale 1ns/1ps
// Snoop-side bus bundle: AC/CR/CD channels, cache lookup/update port and perf counters.
interface ace_snoop_responder_if #(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineWidth = 128
);
  logic                 ac_valid_i;
  logic                 ac_ready_o;
  logic [AddrWidth-1:0] ac_addr_i;
  logic [3:0]           ac_snoop_i;
  logic                 cr_valid_o;
  logic                 cr_ready_i;
  logic [4:0]           cr_resp_o;
  logic                 cd_valid_o;
  logic                 cd_ready_i;
  logic [DataWidth-1:0] cd_data_o;
  logic                 cd_last_o;
  logic                 lk_req_o;
  logic                 lk_gnt_i;
  logic [AddrWidth-1:0] lk_addr_o;
  logic                 lk_rvalid_i;
  logic                 lk_hit_i;
  logic                 lk_dirty_i;
  logic                 lk_shared_i;
  logic [LineWidth-1:0] lk_data_i;
  logic                 upd_req_o;
  logic                 upd_gnt_i;
  logic                 upd_inval_o;
  logic                 upd_clean_o;
  logic [31:0]          hit_cnt_o;
  logic [31:0]          miss_cnt_o;

  modport slave (
    input  ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
           lk_gnt_i, lk_rvalid_i, lk_hit_i, lk_dirty_i, lk_shared_i, lk_data_i, upd_gnt_i,
    output ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           lk_req_o, lk_addr_o, upd_req_o, upd_inval_o, upd_clean_o, hit_cnt_o, miss_cnt_o
  );

  modport master (
    output ac_valid_i, ac_addr_i, ac_snoop_i, cr_ready_i, cd_ready_i,
           lk_gnt_i, lk_rvalid_i, lk_hit_i, lk_dirty_i, lk_shared_i, lk_data_i, upd_gnt_i,
    input  ac_ready_o, cr_valid_o, cr_resp_o, cd_valid_o, cd_data_o, cd_last_o,
           lk_req_o, lk_addr_o, upd_req_o, upd_inval_o, upd_clean_o, hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/snoop_resp_decode.sv
`timescale 1ns/1ps
// Combinational snoop decode: (snoop type, line state) -> CR bits, data need and state update.
// Zero latency, no handshake; unsupported codes answer Error only.
module snoop_resp_decode
  import snoop_resp_pkg::*;
(
  input  logic [3:0] snoop,
  input  logic       hit,
  input  logic       dirty,
  input  logic       shared,
  output snp_dec_t   dec
);

  logic pd;
  logic wu;

  assign pd = hit & dirty;
  assign wu = hit & ~shared;

  always_comb begin
    dec = '0;
    case (snoop)
      SNP_READ_ONCE: begin
        dec.cr_resp[CR_DT] = hit;
        dec.cr_resp[CR_IS] = hit;
      end
      SNP_READ_SHARED, SNP_READ_CLEAN, SNP_READ_NSD: begin
        dec.cr_resp[CR_DT] = hit;
        dec.cr_resp[CR_IS] = hit;
        dec.cr_resp[CR_PD] = pd;
        dec.cr_resp[CR_WU] = wu;
        dec.clean          = pd | wu;
      end
      SNP_READ_UNIQUE: begin
        dec.cr_resp[CR_DT] = hit;
        dec.cr_resp[CR_PD] = pd;
        dec.cr_resp[CR_WU] = wu;
        dec.inval          = hit;
      end
      SNP_CLEAN_INVALID: begin
        dec.cr_resp[CR_DT] = pd;
        dec.cr_resp[CR_PD] = pd;
        dec.cr_resp[CR_WU] = wu;
        dec.inval          = hit;
      end
      SNP_CLEAN_SHARED: begin
        dec.cr_resp[CR_DT] = pd;
        dec.cr_resp[CR_PD] = pd;
        dec.cr_resp[CR_IS] = hit;
        dec.cr_resp[CR_WU] = wu;
        dec.clean          = pd;
      end
      SNP_MAKE_INVALID: begin
        dec.cr_resp[CR_WU] = wu;
        dec.inval          = hit;
      end
      default: dec.cr_resp[CR_ERR] = 1'b1;
    endcase
    dec.need_data = dec.cr_resp[CR_DT];
  end

endmodule

// File: rtl/ace_snoop_responder.sv
`timescale 1ns/1ps
// ACE snoop responder: AC accept -> lookup -> optional update -> CR -> CD beats; 3 cycles AC-to-CR minimum.
// Every handshake may stall indefinitely with outputs held; SNOOP_RESP_PERF_CNT_EN enables hit/miss counters.
module ace_snoop_responder
  import snoop_resp_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int DataWidth = 64,
  parameter int LineWidth = 128
) (
  input logic                  clk_i,
  input logic                  rst_ni,
  ace_snoop_responder_if.slave bus
);

  localparam int NBeats = LineWidth / DataWidth;
  localparam int BeatW  = (NBeats > 1) ? $clog2(NBeats) : 1;
  localparam int OffW   = $clog2(LineWidth / 8);
  localparam logic [BeatW-1:0]     LastBeat = BeatW'(NBeats - 1);
  localparam logic [AddrWidth-1:0] LineMask = {{(AddrWidth-OffW){1'b1}}, {OffW{1'b0}}};

  snp_state_e           state_q;
  logic [AddrWidth-1:0] addr_q;
  logic [3:0]           snoop_q;
  logic [LineWidth-1:0] line_q;
  logic [4:0]           resp_q;
  logic                 need_data_q;
  logic [BeatW-1:0]     beat_q;
  logic                 ac_ready_q;
  logic                 lk_req_q;
  logic                 upd_req_q;
  logic                 upd_inval_q;
  logic                 upd_clean_q;
  logic                 cr_valid_q;
  logic [4:0]           cr_resp_q;
  logic                 cd_valid_q;
  snp_dec_t             dec;

  snoop_resp_decode u_decode (
    .snoop  (snoop_q),
    .hit    (bus.lk_hit_i),
    .dirty  (bus.lk_dirty_i),
    .shared (bus.lk_shared_i),
    .dec    (dec)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      snoop_q     <= '0;
      line_q      <= '0;
      resp_q      <= '0;
      need_data_q <= 1'b0;
      beat_q      <= '0;
      ac_ready_q  <= 1'b1;
      lk_req_q    <= 1'b0;
      upd_req_q   <= 1'b0;
      upd_inval_q <= 1'b0;
      upd_clean_q <= 1'b0;
      cr_valid_q  <= 1'b0;
      cr_resp_q   <= '0;
      cd_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.ac_valid_i) begin
          addr_q     <= bus.ac_addr_i & LineMask;
          snoop_q    <= bus.ac_snoop_i;
          ac_ready_q <= 1'b0;
          lk_req_q   <= 1'b1;
          state_q    <= LOOKUP;
        end
        LOOKUP: if (bus.lk_gnt_i) begin
          lk_req_q <= 1'b0;
          state_q  <= WAIT;
        end
        WAIT: if (bus.lk_rvalid_i) begin
          line_q      <= bus.lk_data_i;
          resp_q      <= dec.cr_resp;
          need_data_q <= dec.need_data;
          if (dec.inval || dec.clean) begin
            upd_req_q   <= 1'b1;
            upd_inval_q <= dec.inval;
            upd_clean_q <= dec.clean;
            state_q     <= UPDATE;
          end else begin
            cr_valid_q <= 1'b1;
            cr_resp_q  <= dec.cr_resp;
            state_q    <= RESP;
          end
        end
        UPDATE: if (bus.upd_gnt_i) begin
          upd_req_q   <= 1'b0;
          upd_inval_q <= 1'b0;
          upd_clean_q <= 1'b0;
          cr_valid_q  <= 1'b1;
          cr_resp_q   <= resp_q;
          state_q     <= RESP;
        end
        RESP: if (bus.cr_ready_i) begin
          cr_valid_q <= 1'b0;
          cr_resp_q  <= '0;
          if (need_data_q) begin
            cd_valid_q <= 1'b1;
            beat_q     <= '0;
            state_q    <= DATA;
          end else begin
            ac_ready_q <= 1'b1;
            state_q    <= IDLE;
          end
        end
        DATA: if (bus.cd_ready_i) begin
          if (beat_q == LastBeat) begin
            cd_valid_q <= 1'b0;
            beat_q     <= '0;
            ac_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            beat_q <= beat_q + BeatW'(1);
          end
        end
        default: begin
          ac_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ac_ready_o  = ac_ready_q;
  assign bus.lk_req_o    = lk_req_q;
  assign bus.lk_addr_o   = addr_q;
  assign bus.upd_req_o   = upd_req_q;
  assign bus.upd_inval_o = upd_inval_q;
  assign bus.upd_clean_o = upd_clean_q;
  assign bus.cr_valid_o  = cr_valid_q;
  assign bus.cr_resp_o   = cr_resp_q;
  assign bus.cd_valid_o  = cd_valid_q;
  assign bus.cd_data_o   = line_q[int'(beat_q)*DataWidth +: DataWidth];
  assign bus.cd_last_o   = cd_valid_q & (beat_q == LastBeat);

`ifdef SNOOP_RESP_PERF_CNT_EN
  logic [31:0] hit_cnt_q;
  logic [31:0] miss_cnt_q;

  // Counters saturate instead of wrapping so long runs never report small values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == WAIT && bus.lk_rvalid_i) begin
      if (bus.lk_hit_i) begin
        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
      end else begin
        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
      end
    end
  end

  assign bus.hit_cnt_o  = hit_cnt_q;
  assign bus.miss_cnt_o = miss_cnt_q;
`else
  assign bus.hit_cnt_o  = '0;
  assign bus.miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ace_snoop_responder.sv
`timescale 1ns/1ps
// Scoreboard bench for ace_snoop_responder: expected lookup address, update, CR and CD beats are queued per snoop.
module tb_ace_snoop_responder;

  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 128;
  localparam int LIMIT = 60;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk_i = ~clk_i;

  ace_snoop_responder_if #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) bus ();

  ace_snoop_responder #(.AddrWidth(AW), .DataWidth(DW), .LineWidth(LW)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int last_lat = -1;
  int stall_changes = 0;
  int cd_beats = 0;
  int exp_hit = 0;
  int exp_miss = 0;

  logic [4:0]    exp_cr[$];
  logic [DW:0]   exp_cd[$];
  logic [1:0]    exp_upd[$];
  logic [AW-1:0] exp_lk[$];

  bit          cr_seen = 0;
  bit          cr_hold_vld = 0;
  bit          cd_hold_vld = 0;
  logic [4:0]  cr_hold;
  logic [DW:0] cd_hold;
  logic [4:0]  e_cr;
  logic [DW:0] e_cd;
  logic [1:0]  e_upd;
  logic [AW-1:0] e_lk;

  // Monitor/scoreboard: sample at negedge, compare each handshake against the queued expectation.
  always @(negedge clk_i) begin
    cyc++;
    if (rst_ni) begin
      if (bus.ac_valid_i && bus.ac_ready_o) acc_cyc = cyc;
      if (bus.cr_valid_o && !cr_seen) last_lat = cyc - acc_cyc;
      cr_seen = bus.cr_valid_o;

      if (bus.lk_req_o && bus.lk_gnt_i) begin
        checks++;
        if (exp_lk.size() == 0) begin
          errors++; $display("FAIL lk_unexpected addr=%h", bus.lk_addr_o);
        end else begin
          e_lk = exp_lk.pop_front();
          if (bus.lk_addr_o !== e_lk) begin
            errors++; $display("FAIL lk_addr got=%h exp=%h", bus.lk_addr_o, e_lk);
          end
        end
      end

      if (bus.upd_req_o && bus.upd_gnt_i) begin
        checks++;
        if (exp_upd.size() == 0) begin
          errors++; $display("FAIL upd_unexpected inval/clean=%b", {bus.upd_inval_o, bus.upd_clean_o});
        end else begin
          e_upd = exp_upd.pop_front();
          if ({bus.upd_inval_o, bus.upd_clean_o} !== e_upd) begin
            errors++; $display("FAIL upd_kind got=%b exp=%b", {bus.upd_inval_o, bus.upd_clean_o}, e_upd);
          end
        end
      end

      if (bus.cr_valid_o) begin
        if (cr_hold_vld && bus.cr_resp_o !== cr_hold) stall_changes++;
        cr_hold = bus.cr_resp_o;
        cr_hold_vld = !bus.cr_ready_i;
      end else begin
        cr_hold_vld = 0;
      end
      if (bus.cr_valid_o && bus.cr_ready_i) begin
        checks++;
        if (exp_cr.size() == 0) begin
          errors++; $display("FAIL cr_unexpected resp=%b", bus.cr_resp_o);
        end else begin
          e_cr = exp_cr.pop_front();
          if (bus.cr_resp_o !== e_cr) begin
            errors++; $display("FAIL cr_resp got=%b exp=%b", bus.cr_resp_o, e_cr);
          end
        end
      end

      if (bus.cd_valid_o) begin
        if (cd_hold_vld && {bus.cd_last_o, bus.cd_data_o} !== cd_hold) stall_changes++;
        cd_hold = {bus.cd_last_o, bus.cd_data_o};
        cd_hold_vld = !bus.cd_ready_i;
      end else begin
        cd_hold_vld = 0;
      end
      if (bus.cd_valid_o && bus.cd_ready_i) begin
        checks++;
        cd_beats++;
        if (exp_cd.size() == 0) begin
          errors++; $display("FAIL cd_unexpected last/data=%h", {bus.cd_last_o, bus.cd_data_o});
        end else begin
          e_cd = exp_cd.pop_front();
          if ({bus.cd_last_o, bus.cd_data_o} !== e_cd) begin
            errors++; $display("FAIL cd_beat got=%h exp=%h", {bus.cd_last_o, bus.cd_data_o}, e_cd);
          end
        end
      end
    end else begin
      cr_seen = 0; cr_hold_vld = 0; cd_hold_vld = 0;
    end
  end

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic expire(input string what);
    checks++; errors++;
    $display("FAIL timeout_%s got=expired exp=handshake", what);
  endtask

  // Stimulus only: plays the snoop initiator and the cache port; all checking happens in the monitor/tasks.
  task automatic drive_snoop(input logic [AW-1:0] addr, input logic [3:0] snp,
                             input bit hit, input bit dirty, input bit shared,
                             input logic [LW-1:0] line, input int gnt_wait, input int cr_wait,
                             input bit cd_toggle, input bit hold_cd);
    int n;
    bus.ac_valid_i = 1'b1; bus.ac_addr_i = addr; bus.ac_snoop_i = snp;
    n = 0; while (!bus.ac_ready_o && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) begin expire("ac"); bus.ac_valid_i = 1'b0; return; end
    tick(); bus.ac_valid_i = 1'b0;
    n = 0; while (!bus.lk_req_o && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) begin expire("lk_req"); return; end
    repeat (gnt_wait) tick();
    bus.lk_gnt_i = 1'b1; tick(); bus.lk_gnt_i = 1'b0;
    repeat (gnt_wait) tick();
    bus.lk_rvalid_i = 1'b1; bus.lk_hit_i = hit; bus.lk_dirty_i = dirty;
    bus.lk_shared_i = shared; bus.lk_data_i = line;
    if (hit) exp_hit++; else exp_miss++;
    tick(); bus.lk_rvalid_i = 1'b0;
    n = 0; while (!bus.upd_req_o && !bus.cr_valid_o && n < LIMIT) begin tick(); n++; end
    if (n >= LIMIT) begin expire("upd_or_cr"); return; end
    if (bus.upd_req_o) begin
      repeat (gnt_wait) tick();
      bus.upd_gnt_i = 1'b1; tick(); bus.upd_gnt_i = 1'b0;
      n = 0; while (!bus.cr_valid_o && n < LIMIT) begin tick(); n++; end
      if (n >= LIMIT) begin expire("cr"); return; end
    end
    repeat (cr_wait) tick();
    bus.cr_ready_i = 1'b1; tick(); bus.cr_ready_i = 1'b0;
    if (hold_cd) begin
      n = 0; while (!bus.cd_valid_o && n < LIMIT) begin tick(); n++; end
      if (n >= LIMIT) expire("cd_valid");
      return;
    end
    n = 0;
    while (!bus.ac_ready_o && n < LIMIT) begin
      bus.cd_ready_i = cd_toggle ? ~bus.cd_ready_i : 1'b1;
      tick(); n++;
    end
    bus.cd_ready_i = 1'b0;
    if (n >= LIMIT) expire("cd_done");
  endtask

  task automatic test_reset();
    #12;
    checks++; if (bus.ac_ready_o !== 1'b1) begin errors++; $display("FAIL rst_ac_ready got=%b exp=1", bus.ac_ready_o); end
    checks++;
    if ({bus.cr_valid_o, bus.cd_valid_o, bus.cd_last_o, bus.lk_req_o, bus.upd_req_o, bus.upd_inval_o, bus.upd_clean_o} !== 7'b0) begin
      errors++; $display("FAIL rst_strobes got=%b exp=0", {bus.cr_valid_o, bus.cd_valid_o, bus.cd_last_o, bus.lk_req_o, bus.upd_req_o, bus.upd_inval_o, bus.upd_clean_o});
    end
    checks++;
    if ({bus.cr_resp_o, bus.lk_addr_o, bus.cd_data_o} !== '0) begin
      errors++; $display("FAIL rst_buses got=%h exp=0", {bus.cr_resp_o, bus.lk_addr_o, bus.cd_data_o});
    end
    checks++;
    if ({bus.hit_cnt_o, bus.miss_cnt_o} !== 64'd0) begin
      errors++; $display("FAIL rst_counters got=%h exp=0", {bus.hit_cnt_o, bus.miss_cnt_o});
    end
    @(posedge clk_i); #1 rst_ni = 1'b1;
    tick(); tick();
    checks++;
    if (bus.ac_ready_o !== 1'b1 || bus.lk_req_o !== 1'b0) begin
      errors++; $display("FAIL rst_release_idle got=%b%b exp=10", bus.ac_ready_o, bus.lk_req_o);
    end
  endtask

  task automatic test_read_shared();
    logic [LW-1:0] line = 128'hA1A2A3A4_A5A6A7A8_B1B2B3B4_B5B6B7B8;
    exp_lk.push_back(64'h8000_0040);
    exp_upd.push_back(2'b01);
    exp_cr.push_back(5'b11101);
    exp_cd.push_back({1'b0, line[63:0]});
    exp_cd.push_back({1'b1, line[127:64]});
    drive_snoop(64'h8000_004C, 4'b0001, 1, 1, 0, line, 0, 0, 0, 0);
    checks++;
    if (exp_lk.size() + exp_upd.size() + exp_cr.size() + exp_cd.size() != 0) begin
      errors++; $display("FAIL rs_drained got=%0d exp=0", exp_lk.size() + exp_upd.size() + exp_cr.size() + exp_cd.size());
    end
  endtask

  task automatic test_read_unique();
    logic [LW-1:0] line = 128'h0123456789ABCDEF_FEDCBA9876543210;
    exp_lk.push_back(64'h8000_0080);
    exp_upd.push_back(2'b10);
    exp_cr.push_back(5'b00001);
    exp_cd.push_back({1'b0, line[63:0]});
    exp_cd.push_back({1'b1, line[127:64]});
    drive_snoop(64'h8000_0080, 4'b0111, 1, 0, 1, line, 1, 1, 0, 0);
    checks++;
    if (exp_lk.size() + exp_upd.size() + exp_cr.size() + exp_cd.size() != 0) begin
      errors++; $display("FAIL ru_drained got=%0d exp=0", exp_lk.size() + exp_upd.size() + exp_cr.size() + exp_cd.size());
    end
  endtask

  task automatic test_clean_invalid_miss();
    int beats0 = cd_beats;
    exp_lk.push_back(64'h0000_1230);
    exp_cr.push_back(5'b00000);
    drive_snoop(64'h0000_1237, 4'b1001, 0, 1, 0, {2{64'hDEAD_BEEF_0000_0001}}, 0, 0, 0, 0);
    checks++;
    if (cd_beats != beats0 || exp_cr.size() != 0) begin
      errors++; $display("FAIL ci_miss_no_cd got=%0d exp=0", cd_beats - beats0);
    end
    checks++;
    if (bus.ac_ready_o !== 1'b1) begin errors++; $display("FAIL ci_miss_idle got=%b exp=1", bus.ac_ready_o); end
  endtask

  task automatic test_make_invalid();
    int beats0 = cd_beats;
    exp_lk.push_back(64'h4000_0100);
    exp_upd.push_back(2'b10);
    exp_cr.push_back(5'b10000);
    drive_snoop(64'h4000_0100, 4'b1101, 1, 1, 0, {2{64'h5555_AAAA_5555_AAAA}}, 2, 0, 0, 0);
    checks++;
    if (cd_beats != beats0 || exp_upd.size() + exp_cr.size() != 0) begin
      errors++; $display("FAIL mi_no_cd got=%0d exp=0", cd_beats - beats0);
    end
  endtask

  task automatic test_clean_shared();
    logic [LW-1:0] line = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    exp_lk.push_back(64'h0000_0FF0);
    exp_upd.push_back(2'b01);
    exp_cr.push_back(5'b01101);
    exp_cd.push_back({1'b0, line[63:0]});
    exp_cd.push_back({1'b1, line[127:64]});
    drive_snoop(64'h0000_0FF8, 4'b1000, 1, 1, 1, line, 0, 2, 0, 0);
    checks++;
    if (exp_upd.size() + exp_cr.size() + exp_cd.size() != 0) begin
      errors++; $display("FAIL cs_drained got=%0d exp=0", exp_upd.size() + exp_cr.size() + exp_cd.size());
    end
  endtask

  task automatic test_unsupported();
    int beats0 = cd_beats;
    exp_lk.push_back(64'h0000_2000);
    exp_cr.push_back(5'b00010);
    drive_snoop(64'h0000_2000, 4'b1011, 1, 1, 0, {2{64'h0F0F_0F0F_0F0F_0F0F}}, 0, 0, 0, 0);
    checks++;
    if (cd_beats != beats0 || exp_cr.size() != 0) begin
      errors++; $display("FAIL unsup_no_cd got=%0d exp=0", cd_beats - beats0);
    end
  endtask

  task automatic test_back_to_back();
    logic [LW-1:0] line = 128'hCAFE0000_CAFE0001_CAFE0002_CAFE0003;
    exp_lk.push_back(64'h0000_0300);
    exp_cr.push_back(5'b00000);
    last_lat = -1;
    drive_snoop(64'h0000_0300, 4'b0000, 0, 0, 0, line, 0, 0, 0, 0);
    checks++; if (last_lat != 3) begin errors++; $display("FAIL latency_miss got=%0d exp=3", last_lat); end
    exp_lk.push_back(64'h0000_0310);
    exp_cr.push_back(5'b01001);
    exp_cd.push_back({1'b0, line[63:0]});
    exp_cd.push_back({1'b1, line[127:64]});
    last_lat = -1;
    drive_snoop(64'h0000_0310, 4'b0000, 1, 0, 1, line, 0, 0, 0, 0);
    checks++; if (last_lat != 3) begin errors++; $display("FAIL latency_hit got=%0d exp=3", last_lat); end
  endtask

  task automatic test_backpressure();
    logic [LW-1:0] line = 128'h9999_8888_7777_6666_5555_4444_3333_2222;
    int beats0 = cd_beats;
    stall_changes = 0;
    exp_lk.push_back(64'h8000_0400);
    exp_cr.push_back(5'b01001);
    exp_cd.push_back({1'b0, line[63:0]});
    exp_cd.push_back({1'b1, line[127:64]});
    drive_snoop(64'h8000_0400, 4'b0010, 1, 0, 1, line, 3, 10, 1, 0);
    checks++; if (stall_changes != 0) begin errors++; $display("FAIL bp_stable got=%0d exp=0", stall_changes); end
    checks++; if (cd_beats - beats0 != 2) begin errors++; $display("FAIL bp_beats got=%0d exp=2", cd_beats - beats0); end
  endtask

  task automatic test_reset_mid_data();
    logic [LW-1:0] line = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000_1111;
    int bad = 0;
    exp_lk.push_back(64'h8000_0080);
    exp_upd.push_back(2'b10);
    exp_cr.push_back(5'b00001);
    drive_snoop(64'h8000_0080, 4'b0111, 1, 0, 1, line, 0, 0, 0, 1);
    checks++; if (bus.cd_valid_o !== 1'b1) begin errors++; $display("FAIL rmd_in_data got=%b exp=1", bus.cd_valid_o); end
    #2 rst_ni = 1'b0;
    #1;
    checks++;
    if ({bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.cd_last_o, bus.lk_req_o, bus.upd_req_o} !== 6'b100000) begin
      errors++; $display("FAIL rmd_async got=%b exp=100000", {bus.ac_ready_o, bus.cr_valid_o, bus.cd_valid_o, bus.cd_last_o, bus.lk_req_o, bus.upd_req_o});
    end
    checks++;
    if ({bus.cd_data_o, bus.cr_resp_o, bus.hit_cnt_o} !== '0) begin
      errors++; $display("FAIL rmd_async_data got=%h exp=0", {bus.cd_data_o, bus.cr_resp_o, bus.hit_cnt_o});
    end
    exp_cd.delete();
    exp_hit = 0; exp_miss = 0;
    tick(); tick();
    rst_ni = 1'b1;
    repeat (6) begin
      tick();
      if (bus.cr_valid_o || bus.cd_valid_o || bus.lk_req_o) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rmd_quiet got=%0d exp=0", bad); end
    exp_lk.push_back(64'h0000_0500);
    exp_cr.push_back(5'b01001);
    exp_cd.push_back({1'b0, line[63:0]});
    exp_cd.push_back({1'b1, line[127:64]});
    drive_snoop(64'h0000_0500, 4'b0000, 1, 0, 1, line, 0, 0, 0, 0);
    checks++;
    if (exp_lk.size() + exp_upd.size() + exp_cr.size() + exp_cd.size() != 0) begin
      errors++; $display("FAIL rmd_drained got=%0d exp=0", exp_lk.size() + exp_upd.size() + exp_cr.size() + exp_cd.size());
    end
  endtask

  task automatic test_counters();
    int eh;
    int em;
`ifdef SNOOP_RESP_PERF_CNT_EN
    eh = exp_hit; em = exp_miss;
`else
    eh = 0; em = 0;
`endif
    checks++; if (bus.hit_cnt_o !== 32'(eh)) begin errors++; $display("FAIL hit_cnt got=%0d exp=%0d", bus.hit_cnt_o, eh); end
    checks++; if (bus.miss_cnt_o !== 32'(em)) begin errors++; $display("FAIL miss_cnt got=%0d exp=%0d", bus.miss_cnt_o, em); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ac_valid_i = 1'b0; bus.ac_addr_i = '0; bus.ac_snoop_i = '0;
    bus.cr_ready_i = 1'b0; bus.cd_ready_i = 1'b0;
    bus.lk_gnt_i = 1'b0; bus.lk_rvalid_i = 1'b0;
    bus.lk_hit_i = 1'b0; bus.lk_dirty_i = 1'b0; bus.lk_shared_i = 1'b0; bus.lk_data_i = '0;
    bus.upd_gnt_i = 1'b0;
    test_reset();
    test_read_shared();
    test_read_unique();
    test_clean_invalid_miss();
    test_make_invalid();
    test_clean_shared();
    test_unsupported();
    test_back_to_back();
    test_backpressure();
    test_counters();
    test_reset_mid_data();
    test_counters();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
